// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// One frame bit per CLK cycle; outputs are registered from the next state.
module uart_tx #(
  parameter int Data_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = $clog2(Data_Width);
  localparam logic [CW-1:0] LAST = CW'(Data_Width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                nxt;
  logic [Data_Width-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par_en_q;
  logic                  par_q;
  logic                  tx_d;
  logic                  busy_d;
  logic                  last;

  assign last = (cnt == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (Data_Valid) nxt = START;
      START:   nxt = DATA;
      DATA:    if (last) nxt = par_en_q ? PARITY : STOP;
      PARITY:  nxt = STOP;
      STOP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Staying in DATA means the register shifts at this edge,
  // so the bit that goes out next is shreg[1].
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (nxt)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = (state == DATA) ? shreg[1] : shreg[0];
      PARITY:  tx_d   = par_q;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      Busy   <= busy_d;
      if (state == IDLE && Data_Valid) begin
        shreg    <= P_DATA;
        par_en_q <= PAR_EN;
        par_q    <= (^P_DATA) ^ PAR_TYP;
      end
      if (state == START) cnt <= '0;
      if (state == DATA) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: vector table of frames plus
// back-to-back, busy-ignore and mid-frame reset sequences.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(.Data_Width(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       par;
    int         len;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] d, input logic pe,
                                input logic par, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9 && pe) return par;
    return 1'b1;
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d,
                             input logic pe, input logic par, input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge CLK);
      chk($sformatf("%s bit%0d", tag, j), TX_OUT, fbit(d, pe, par, j));
      chk($sformatf("%s busy%0d", tag, j), Busy, 1'b1);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      chk($sformatf("%s idle_tx%0d", tag, j), TX_OUT, 1'b1);
      chk($sformatf("%s idle_busy%0d", tag, j), Busy, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, par: 1'b0, len: 10};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, par: 1'b0, len: 11};
    vecs[2] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, par: 1'b1, len: 11};
    vecs[3] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, par: 1'b1, len: 11};
    vecs[4] = '{data: 8'hFF, pe: 1'b1, pt: 1'b1, par: 1'b1, len: 11};

    // reset state
    #12;
    chk("rst tx", TX_OUT, 1'b1);
    chk("rst busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("post_rst", 20);

    // vector table
    foreach (vecs[i]) begin
      @(negedge CLK);
      accept(vecs[i].data, vecs[i].pe, vecs[i].pt);
      check_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pe,
                  vecs[i].par, vecs[i].len);
      check_idle($sformatf("vec%0d", i), 2);
    end

    // back-to-back: Data_Valid held, data switched mid-frame
    @(negedge CLK);
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 P_DATA = 8'hC3;
    check_frame("b2b1", 8'h3C, 1'b0, 1'b0, 10);
    check_idle("b2b_gap", 1);
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
    check_frame("b2b2", 8'hC3, 1'b0, 1'b0, 10);
    check_idle("b2b_end", 3);

    // request while busy is ignored
    @(negedge CLK);
    accept(8'h55, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      chk($sformatf("ign bit%0d", j), TX_OUT, fbit(8'h55, 1'b0, 1'b0, j));
      chk($sformatf("ign busy%0d", j), Busy, 1'b1);
      if (j == 3) begin
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        Data_Valid = 1'b1;
      end
      if (j == 4) Data_Valid = 1'b0;
    end
    check_idle("ign_end", 6);

    // mid-frame reset during data bit 3 of 0x0F
    @(negedge CLK);
    accept(8'h0F, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk($sformatf("mrst bit%0d", j), TX_OUT, fbit(8'h0F, 1'b0, 1'b0, j));
    end
    @(negedge CLK);
    chk("mrst busy_before", Busy, 1'b1);
    #1 RST = 1'b0;
    #1;
    chk("mrst tx", TX_OUT, 1'b1);
    chk("mrst busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("mrst_after", 4);
    @(negedge CLK);
    accept(8'h81, 1'b0, 1'b0);
    check_frame("mrst_81", 8'h81, 1'b0, 1'b0, 10);
    check_idle("mrst_end", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
